// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst memory subordinate backed by a word-addressed array.
// Optional macro AXI_SLVERR_EN: out-of-range word indices answer SLVERR instead of wrapping.
module axi_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [LEN_WIDTH-1:0]    i_arlen,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [LEN_WIDTH-1:0]    i_awlen,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = ADDR_WIDTH - BYTE_SHIFT;
    localparam int MEM_AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        WRESP = 2'b11
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   active_r;
    logic [IDX_W-1:0]       idx_r;
    logic [LEN_WIDTH-1:0]   cnt_r;
    logic [LEN_WIDTH-1:0]   len_r;
    logic [1:0]             bresp_r;

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic                   idle_s;
    logic                   aw_hs_s;
    logic                   ar_hs_s;
    logic                   r_hs_s;
    logic                   w_hs_s;
    logic                   b_hs_s;
    logic                   last_s;
    logic                   oor_s;
    logic                   wr_en_s;
    logic [MEM_AW-1:0]      mem_idx_s;
    logic [DATA_WIDTH-1:0]  rd_word_s;
    logic                   unused_s;

    function automatic logic [DATA_WIDTH-1:0] strb_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

`ifdef AXI_SLVERR_EN
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);

    function automatic logic idx_out_of_range(input logic [IDX_W-1:0] idx);
        return (idx >= DEPTH_IDX);
    endfunction
`endif

    assign unused_s = ^{i_wlast, i_araddr, i_awaddr};

    // Array index, range check and raw read word for the current beat.
    always_comb begin
        mem_idx_s = idx_r[MEM_AW-1:0];
`ifdef AXI_SLVERR_EN
        oor_s     = idx_out_of_range(idx_r);
        wr_en_s   = ~oor_s;
        rd_word_s = oor_s ? {DATA_WIDTH{1'b0}} : mem[mem_idx_s];
`else
        oor_s     = 1'b0;
        wr_en_s   = 1'b1;
        rd_word_s = mem[mem_idx_s];
`endif
    end

    // Channel outputs and handshake strobes decoded from the current state.
    always_comb begin
        idle_s    = active_r && (state_r == IDLE);
        o_awready = idle_s;
        // Writes win a simultaneous request so a dirty write-back precedes its refill.
        o_arready = idle_s && !i_awvalid;
        o_rvalid  = (state_r == READ);
        o_wready  = (state_r == WRITE);
        o_bvalid  = (state_r == WRESP);
        last_s    = (cnt_r == len_r);
        o_rlast   = o_rvalid && last_s;
        o_rdata   = o_rvalid ? rd_word_s : {DATA_WIDTH{1'b0}};
        o_rresp   = (o_rvalid && oor_s) ? RESP_SLVERR : RESP_OKAY;
        o_bresp   = o_bvalid ? bresp_r : RESP_OKAY;
        aw_hs_s   = i_awvalid && o_awready;
        ar_hs_s   = i_arvalid && o_arready;
        r_hs_s    = o_rvalid && i_rready;
        w_hs_s    = i_wvalid && o_wready;
        b_hs_s    = o_bvalid && i_bready;
    end

    // Next-state logic for the burst FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (aw_hs_s) begin
                    state_nxt_s = WRITE;
                end else if (ar_hs_s) begin
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (r_hs_s && last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = READ;
                end
            end
            WRITE: begin
                if (w_hs_s && last_s) begin
                    state_nxt_s = WRESP;
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            WRESP: begin
                if (b_hs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WRESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register; active_r keeps the address channels closed during reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r  <= IDLE;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            active_r <= 1'b1;
        end
    end

    // Burst bookkeeping: word index, beat counter, length and sticky write response.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= {LEN_WIDTH{1'b0}};
            len_r   <= {LEN_WIDTH{1'b0}};
            bresp_r <= RESP_OKAY;
        end else begin
            case (state_r)
                IDLE: begin
                    if (aw_hs_s) begin
                        idx_r   <= i_awaddr[ADDR_WIDTH-1:BYTE_SHIFT];
                        len_r   <= i_awlen;
                        cnt_r   <= {LEN_WIDTH{1'b0}};
                        bresp_r <= RESP_OKAY;
                    end else if (ar_hs_s) begin
                        idx_r   <= i_araddr[ADDR_WIDTH-1:BYTE_SHIFT];
                        len_r   <= i_arlen;
                        cnt_r   <= {LEN_WIDTH{1'b0}};
                    end
                end
                READ: begin
                    if (r_hs_s) begin
                        idx_r <= idx_r + IDX_W'(1);
                        cnt_r <= cnt_r + LEN_WIDTH'(1);
                    end
                end
                WRITE: begin
                    if (w_hs_s) begin
                        idx_r <= idx_r + IDX_W'(1);
                        cnt_r <= cnt_r + LEN_WIDTH'(1);
                        if (oor_s) begin
                            bresp_r <= RESP_SLVERR;
                        end
                    end
                end
                default: begin
                    bresp_r <= bresp_r;
                end
            endcase
        end
    end

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_hs_s && wr_en_s) begin
            mem[mem_idx_s] <= strb_merge(mem[mem_idx_s], i_wdata, i_wstrb);
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: stimulus pushes expected R/B beats, a monitor pops and compares.
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        arst;
    logic [31:0] i_araddr;
    logic [7:0]  i_arlen;
    logic        i_arvalid;
    logic        o_arready;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp;
    logic        o_rlast;
    logic        o_rvalid;
    logic        i_rready;
    logic [31:0] i_awaddr;
    logic [7:0]  i_awlen;
    logic        i_awvalid;
    logic        o_awready;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        i_wlast;
    logic        i_wvalid;
    logic        o_wready;
    logic [1:0]  o_bresp;
    logic        o_bvalid;
    logic        i_bready;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    logic [31:0] wbuf [4];
    int          checks = 0;
    int          errors = 0;

    axi_mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(4096), .LEN_WIDTH(8)
    ) dut (
        .clk(clk), .arst(arst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pop and compare every R and B handshake.
    always @(negedge clk) begin
        if (!arst) begin
            if (o_rvalid && i_rready) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected", {o_rdata, o_rresp, o_rlast}, 64'd0);
                end else begin
                    rbeat_t e;
                    e = rq.pop_front();
                    chk("r_beat", {29'd0, o_rdata, o_rresp, o_rlast}, {29'd0, e});
                end
            end
            if (o_bvalid && i_bready) begin
                if (bq.size() == 0) begin
                    chk("b_unexpected", {62'd0, o_bresp}, 64'hFFFF);
                end else begin
                    logic [1:0] eb;
                    eb = bq.pop_front();
                    chk("b_resp", {62'd0, o_bresp}, {62'd0, eb});
                end
            end
        end
    end

    task automatic hs_wait(input int kind);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if ((kind == 0 && o_awready) || (kind == 1 && o_arready) || (kind == 2 && o_wready)) return;
            n++;
            if (n > 20) begin
                chk("hs_timeout", 64'(kind), 64'hFF);
                return;
            end
        end
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len);
        i_araddr = addr; i_arlen = len; i_arvalid = 1'b1;
        hs_wait(1);
        @(posedge clk); #1;
        i_arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [3:0] strb, input logic [1:0] exp_b);
        bq.push_back(exp_b);
        i_awaddr = addr; i_awlen = len; i_awvalid = 1'b1;
        hs_wait(0);
        @(posedge clk); #1;
        i_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            i_wdata = wbuf[i]; i_wstrb = strb; i_wlast = (i == int'(len)); i_wvalid = 1'b1;
            hs_wait(2);
            @(posedge clk); #1;
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        @(negedge clk);
        chk("b_latency", {63'd0, o_bvalid}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len);
        int n;
        ar_phase(addr, len);
        n = 0;
        forever begin
            @(negedge clk);
            if (n == 0) chk("r_latency", {63'd0, o_rvalid}, 64'd1);
            if (o_rvalid && i_rready && o_rlast) break;
            n++;
            if (n > 40) begin
                chk("r_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic l);
        rbeat_t e;
        e.data = d; e.resp = r; e.last = l;
        rq.push_back(e);
    endtask

    initial begin
        arst = 1'b1;
        i_araddr = 32'd0; i_arlen = 8'd0; i_arvalid = 1'b0; i_rready = 1'b1;
        i_awaddr = 32'd0; i_awlen = 8'd0; i_awvalid = 1'b0;
        i_wdata = 32'd0; i_wstrb = 4'd0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_ready", {62'd0, o_arready, o_awready}, 64'd0);
        chk("rst_valid", {61'd0, o_rvalid, o_wready, o_bvalid}, 64'd0);
        chk("rst_rlast", {63'd0, o_rlast}, 64'd0);
        chk("rst_rdata", {32'd0, o_rdata}, 64'd0);
        chk("rst_resp", {60'd0, o_rresp, o_bresp}, 64'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Preload 1..4 and read back as a 4-beat burst.
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        do_write(32'h0, 8'd3, 4'hF, 2'b00);
        for (int i = 0; i < 4; i++) push_r(32'(i + 1), 2'b00, i == 3);
        do_read(32'h0, 8'd3);

        wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
        do_write(32'h10, 8'd3, 4'hF, 2'b00);
        for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), 2'b00, i == 3);
        do_read(32'h10, 8'd3);

        // Byte strobes.
        wbuf[0] = 32'h11223344;
        do_write(32'h20, 8'd0, 4'hF, 2'b00);
        wbuf[0] = 32'hDEADBEEF;
        do_write(32'h20, 8'd0, 4'b0101, 2'b00);
        push_r(32'h11AD33EF, 2'b00, 1'b1);
        do_read(32'h20, 8'd0);

        // Simultaneous AW and AR: write first, read right after the B handshake.
        i_awaddr = 32'h30; i_awlen = 8'd0; i_awvalid = 1'b1;
        i_araddr = 32'h0;  i_arlen = 8'd0; i_arvalid = 1'b1;
        @(negedge clk);
        chk("tie_arready", {63'd0, o_arready}, 64'd0);
        chk("tie_awready", {63'd0, o_awready}, 64'd1);
        @(posedge clk); #1;
        i_awvalid = 1'b0;
        i_wdata = 32'h55; i_wstrb = 4'hF; i_wlast = 1'b1; i_wvalid = 1'b1;
        bq.push_back(2'b00);
        push_r(32'd1, 2'b00, 1'b1);
        @(negedge clk);
        chk("tie_ar_held", {62'd0, o_arready, o_wready}, 64'd1);
        @(posedge clk); #1;
        i_wvalid = 1'b0; i_wlast = 1'b0;
        @(negedge clk);
        chk("tie_bvalid", {63'd0, o_bvalid}, 64'd1);
        @(negedge clk);
        chk("tie_ar_idle", {63'd0, o_arready}, 64'd1);
        @(posedge clk); #1;
        i_arvalid = 1'b0;
        @(negedge clk);
        chk("tie_rvalid", {63'd0, o_rvalid}, 64'd1);
        @(posedge clk); #1;

        // rready pattern 1,0,0,1 on a 2-beat read.
        push_r(32'hA0, 2'b00, 1'b0);
        push_r(32'hA1, 2'b00, 1'b1);
        ar_phase(32'h10, 8'd1);
        @(posedge clk); #1;
        i_rready = 1'b0;
        @(negedge clk);
        chk("stall_1", {31'd0, o_rdata, o_rlast}, {31'd0, 32'hA1, 1'b1});
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_2", {31'd0, o_rdata, o_rlast}, {31'd0, 32'hA1, 1'b1});
        @(posedge clk); #1;
        i_rready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_done", {63'd0, o_rvalid}, 64'd0);
        @(posedge clk); #1;

        // Last word of the array followed by the out-of-range/wrapped word.
        wbuf[0] = 32'h77;
        do_write(32'h3FFC, 8'd0, 4'hF, 2'b00);
        push_r(32'h77, 2'b00, 1'b0);
`ifdef AXI_SLVERR_EN
        push_r(32'h0, 2'b10, 1'b1);
`else
        push_r(32'd1, 2'b00, 1'b1);
`endif
        do_read(32'h3FFC, 8'd1);

        wbuf[0] = 32'h99; wbuf[1] = 32'h88;
`ifdef AXI_SLVERR_EN
        do_write(32'h3FFC, 8'd1, 4'hF, 2'b10);
        push_r(32'h99, 2'b00, 1'b1);
        do_read(32'h3FFC, 8'd0);
`else
        do_write(32'h3FFC, 8'd1, 4'hF, 2'b00);
        push_r(32'h88, 2'b00, 1'b1);
        do_read(32'h0, 8'd0);
`endif

        // Reset in the middle of a stalled read.
        i_rready = 1'b0;
        ar_phase(32'h0, 8'd3);
        #2;
        chk("mid_rvalid", {63'd0, o_rvalid}, 64'd1);
        arst = 1'b1;
        #1;
        chk("mid_rst_out", {60'd0, o_rvalid, o_rlast, o_arready, o_awready}, 64'd0);
        chk("mid_rst_rdata", {32'd0, o_rdata}, 64'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        i_rready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("post_rst_idle", {62'd0, o_arready, o_rvalid}, 64'd2);

        chk("rq_empty", 64'(rq.size()), 64'd0);
        chk("bq_empty", 64'(bq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 memory subordinate that answers the cache-refill and write-back bursts issued by the core's control unit and data/instruction cache FSMs. It accepts an address on AR or AW, then streams an INCR burst of words from, or into, an internal word-addressed memory array. Reads end with RLAST; writes end with a B response. It is the memory-side end of the core's AXI link and is used as the simulation and FPGA main memory.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per beat (power of two, ≥ 8)
- ADDR_WIDTH, 32, byte-address width
- MEM_DEPTH, 4096, number of DATA_WIDTH words in the array
- LEN_WIDTH, 8, burst length field width (beats = len + 1)

Ports:
- clk  in  1  clock, rising edge
- arst  in  1  asynchronous, active-high reset
- i_araddr  in  ADDR_WIDTH  read burst start byte address
- i_arlen  in  LEN_WIDTH  read beats − 1
- i_arvalid / o_arready  in/out  1  AR handshake
- o_rdata  out  DATA_WIDTH  read data
- o_rresp  out  2  read response
- o_rlast  out  1  final read beat
- o_rvalid / i_rready  out/in  1  R handshake
- i_awaddr  in  ADDR_WIDTH  write burst start byte address
- i_awlen  in  LEN_WIDTH  write beats − 1
- i_awvalid / o_awready  in/out  1  AW handshake
- i_wdata  in  DATA_WIDTH  write data
- i_wstrb  in  DATA_WIDTH/8  byte enables
- i_wlast  in  1  final write beat (informational)
- i_wvalid / o_wready  in/out  1  W handshake
- o_bresp  out  2  write response
- o_bvalid / i_bready  out/in  1  B handshake

## Operation
- FSM states: IDLE, READ, WRITE, WRESP.
- Word index = byte address >> log2(DATA_WIDTH/8). Low address bits are ignored; bursts are INCR only.
- IDLE:
  - o_awready = 1.
  - o_arready = ~i_awvalid, so writes win a simultaneous request. This keeps a dirty write-back ahead of the refill.
  - On an AW handshake: latch the address and len, clear the beat counter, go to WRITE.
  - On an AR handshake: latch the address and len, clear the beat counter, go to READ.
- READ:
  - o_rvalid = 1.
  - o_rdata = mem[word index] (combinational array read).
  - o_rlast = (beat counter == len).
  - On each rvalid&rready: increment the word index and beat counter. When the handshaked beat has rlast set, go to IDLE.
  - o_rdata, o_rlast and o_rresp hold stable while rready is low.
- WRITE:
  - o_wready = 1.
  - On each wvalid&wready: write mem[word index] byte-wise under i_wstrb, then increment the index and counter.
  - When the beat with counter == len is accepted, go to WRESP. i_wlast does not affect termination.
- WRESP:
  - o_bvalid = 1 with o_bresp.
  - On bvalid&bready, go to IDLE.
- Word-index arithmetic:
  - The counter is LEN_WIDTH bits wide.
  - The word index increments modulo 2^(ADDR_WIDTH−log2 bytes).
  - Array access uses the index modulo MEM_DEPTH (see Configuration for the out-of-range case).
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.

## Timing
- Reset values: all ready/valid outputs 0, o_rlast 0, o_rresp/o_bresp 2'b00, o_rdata 0, state IDLE. Memory contents are not reset.
- Reset asserted mid-burst aborts the burst immediately. No B response is issued for the aborted write; beats already written remain in memory.
- Read latency: the first R beat is valid in the cycle after the AR handshake. With rready held high, one beat per cycle; an N-beat burst completes N cycles after the AR handshake.
- Write: one beat per cycle while wvalid is high. o_bvalid asserts the cycle after the last W handshake.
- The cycle after the final R or B handshake is IDLE; the earliest next address handshake is in that cycle.
- Only one burst is outstanding; AR and AW are never both accepted in the same cycle.

## Configuration
- AXI_SLVERR_EN defined:
  - An address whose word index is ≥ MEM_DEPTH, at burst start or reached mid-burst, returns SLVERR for that beat (read) or marks o_bresp = SLVERR for the burst (write).
  - Out-of-range write beats are discarded. Out-of-range read data is 0.
- AXI_SLVERR_EN undefined: the index wraps modulo MEM_DEPTH and every response is OKAY.

## Test plan
- Preload mem[0..3] = 1,2,3,4 → AR addr 0x0, len 3, rready = 1 → rdata 1,2,3,4 on 4 consecutive cycles starting 1 cycle after AR; rlast only on beat 4; rresp 0.
- AW addr 0x10, len 3, W data A0..A3, wstrb 0xF → bvalid 1 cycle after the last W handshake, bresp 0. A following read of 0x10, len 3 returns A0..A3.
- Write 0xDEADBEEF with wstrb 0b0101 over 0x11223344 at 0x20 → read returns 0x11AD33EF.
- AR and AW valid in the same IDLE cycle → AW accepted and arready = 0 that cycle. The AR is accepted in the first IDLE cycle after the B handshake.
- Toggle rready 1,0,0,1 during a 2-beat read → rdata/rlast stable while stalled; burst completes with exactly 2 handshakes.
- Boundary case, AR at word MEM_DEPTH−1, len 1:
  - With AXI_SLVERR_EN: beat 1 OKAY, beat 2 SLVERR with data 0.
  - Without it: beat 2 returns mem[0]. Assert arst mid-burst → all valids 0 asynchronously, state IDLE.
